multiplier_controller_tainttrack: RTL and testbench

- FSM that sequences the taint-tracking shift-add multiplier datapath (MultiplierDatapath_TaintTrack).
- Drives the mdld/mrld/rsclear/rsload/rsshr strobes and their _t companions.
- Examines one multiplierReg bit per iteration and reports completion.
- Propagates control-flow taint: once a decision depends on tainted data, every subsequent control output of that operation is marked tainted.

---
 rtl/multiplier_controller_tainttrack_if.sv | 35 +++
 rtl/multiplier_controller_tainttrack.sv | 113 +++++++++++
 tb/tb_multiplier_controller_tainttrack.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/multiplier_controller_tainttrack_if.sv
// Handshake and strobe bundle between the multiplier controller (master)
// and the requester/datapath side (slave); every signal carries a taint companion.
interface multiplier_controller_tainttrack_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] multiplierReg;
    logic [WIDTH-1:0] multiplierReg_t;
    logic             mdld;
    logic             mdld_t;
    logic             mrld;
    logic             mrld_t;
    logic             rsclear;
    logic             rsclear_t;
    logic             rsload;
    logic             rsload_t;
    logic             rsshr;
    logic             rsshr_t;
    logic             busy;
    logic             done;
    logic             done_t;

    modport master (
        input  start, start_t, multiplierReg, multiplierReg_t,
        output mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t, busy, done, done_t
    );

    modport slave (
        output start, start_t, multiplierReg, multiplierReg_t,
        input  mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t, busy, done, done_t
    );
endinterface

// File: rtl/multiplier_controller_tainttrack.sv
// Shift-add multiplier sequencer: one multiplier bit per EVAL, an extra SHIFT cycle
// for set bits, and sticky control-flow taint once any decision depends on tainted data.
module multiplier_controller_tainttrack #(
    parameter int WIDTH = 4
) (
    input logic                                clk,
    input logic                                rst,
    multiplier_controller_tainttrack_if.master bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          flow_t_q, flow_t_d;
    logic          bit_v;
    logic          bit_t;
    logic          eff_t;

    assign bit_v = bus.multiplierReg[count_q];
    assign bit_t = bus.multiplierReg_t[count_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            flow_t_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            flow_t_q <= flow_t_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        flow_t_d = flow_t_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_INIT;
                    flow_t_d = bus.start_t;
                end
            end
            S_INIT: begin
                count_d = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                // The branch taken here depends on the bit, so its taint sticks.
                flow_t_d = flow_t_q | bit_t;
                if (bit_v) begin
                    state_d = S_SHIFT;
                end else if (count_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (count_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mdld    = 1'b0;
        bus.mrld    = 1'b0;
        bus.rsclear = 1'b0;
        bus.rsload  = 1'b0;
        bus.rsshr   = 1'b0;
        bus.done    = 1'b0;
        bus.busy    = (state_q != S_IDLE);
        eff_t       = flow_t_q | ((state_q == S_EVAL) & bit_t);
        case (state_q)
            S_INIT: begin
                bus.mdld    = 1'b1;
                bus.mrld    = 1'b1;
                bus.rsclear = 1'b1;
            end
            S_EVAL: begin
                bus.rsload = bit_v;
                bus.rsshr  = ~bit_v;
            end
            S_SHIFT: bus.rsshr = 1'b1;
            S_DONE:  bus.done  = 1'b1;
            default: ;
        endcase
        // Taint marks every control output of a live operation, asserted or not.
        bus.mdld_t    = bus.busy & eff_t;
        bus.mrld_t    = bus.busy & eff_t;
        bus.rsclear_t = bus.busy & eff_t;
        bus.rsload_t  = bus.busy & eff_t;
        bus.rsshr_t   = bus.busy & eff_t;
        bus.done_t    = bus.busy & eff_t;
    end
endmodule

// File: tb/tb_multiplier_controller_tainttrack.sv
// Directed bench: a behavioural shift-add datapath closes the loop around the controller;
// strobe sequences, taint vectors, latency and products are checked against hand values.
module tb_multiplier_controller_tainttrack;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplier_controller_tainttrack_if #(.WIDTH(4)) bus ();
    multiplier_controller_tainttrack #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath model: sum is added into the upper half, then shifted right once per bit.
    logic [3:0] a_in = '0, b_in = '0, bt_in = '0;
    logic [3:0] md = '0, mr = '0, mr_t = '0;
    logic [8:0] rs = '0;
    always @(posedge clk) begin
        if (bus.mdld) md <= a_in;
        if (bus.mrld) begin
            mr   <= b_in;
            mr_t <= bt_in;
        end
        if (bus.rsclear)     rs <= '0;
        else if (bus.rsload) rs[8:4] <= rs[8:4] + {1'b0, md};
        else if (bus.rsshr)  rs <= rs >> 1;
    end
    assign bus.multiplierReg   = mr;
    assign bus.multiplierReg_t = mr_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cyc, nload, nshr;
    logic [63:0] seq;
    logic [15:0] tvec;
    logic        tcons;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.mdld, bus.mdld_t, bus.mrld, bus.mrld_t, bus.rsclear, bus.rsclear_t,
                bus.rsload, bus.rsload_t, bus.rsshr, bus.rsshr_t, bus.busy, bus.done, bus.done_t};
    endfunction

    // Called at a negedge with the controller idle; returns at the DONE negedge.
    // Per-cycle code: 1 INIT, 2 rsload, 3 rsshr, 4 done, B not busy, E/F illegal strobe mix.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] bt,
                          input logic st, input logic hold, input int pulse_at);
        logic [3:0] code;
        logic [5:0] tv;
        a_in = a; b_in = b; bt_in = bt;
        bus.start = 1'b1; bus.start_t = st;
        seq = '0; tvec = '0; nload = 0; nshr = 0; done_cyc = 0; tcons = 1'b1;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.mdld & bus.mrld & bus.rsclear & ~bus.rsload & ~bus.rsshr) code = 4'h1;
            else if (bus.mdld | bus.mrld | bus.rsclear)                       code = 4'hF;
            else if (bus.rsload & bus.rsshr)                                   code = 4'hE;
            else if (bus.rsload)                                               code = 4'h2;
            else if (bus.rsshr)                                                code = 4'h3;
            else if (bus.done)                                                 code = 4'h4;
            else                                                               code = 4'h0;
            if (!bus.busy) code = 4'hB;
            seq = {seq[59:0], code};
            tv  = {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t, bus.done_t};
            if (tv != 6'h00 && tv != 6'h3F) tcons = 1'b0;
            tvec[c] = bus.mdld_t;
            if (bus.rsload) nload++;
            if (bus.rsshr)  nshr++;
            if (bus.done)   done_cyc = c;
            if (!hold) bus.start = (c == pulse_at);
        end
        chk("no_timeout", done_cyc != 0, 1'b1);
    endtask

    task automatic check_op(input string tag, input logic [63:0] e_seq, input int e_done,
                            input logic [15:0] e_t, input int e_load, input int e_prod);
        chk({tag, "_seq"},   seq, e_seq);
        chk({tag, "_done"},  done_cyc, e_done);
        chk({tag, "_taint"}, tvec, e_t);
        chk({tag, "_tcons"}, tcons, 1'b1);
        chk({tag, "_loads"}, nload, e_load);
        chk({tag, "_shr"},   nshr, 4);
        chk({tag, "_prod"},  rs[7:0], e_prod);
    endtask

    initial begin
        int busy_seen;
        rst = 1'b1; bus.start = 1'b1; bus.start_t = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), '0);
        rst = 1'b0; bus.start = 1'b0; bus.start_t = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), '0);

        run_op(4'd3, 4'd5, 4'b0000, 1'b0, 1'b0, 0);
        check_op("plain3x5", 64'h12332334, 8, 16'h0000, 2, 15);
        @(negedge clk);
        chk("plain_idle", outs(), '0);

        run_op(4'd3, 4'd5, 4'b0010, 1'b0, 1'b0, 0);
        check_op("tbit3x5", 64'h12332334, 8, 16'h01F0, 2, 15);
        @(negedge clk);
        chk("tbit_idle", outs(), '0);

        run_op(4'd15, 4'd15, 4'b0000, 1'b1, 1'b0, 0);
        check_op("tstart15x15", 64'h1232323234, 10, 16'h07FE, 4, 225);
        @(negedge clk);
        chk("tstart_idle_sticky_hidden", outs(), '0);

        run_op(4'd9, 4'd0, 4'b0000, 1'b0, 1'b0, 0);
        check_op("zero", 64'h133334, 6, 16'h0000, 0, 0);
        @(negedge clk);

        // Abort during the second EVAL (bit 1 of 5 is 0, so rsshr is showing).
        a_in = 4'd3; b_in = 4'd5; bt_in = 4'b0000;
        bus.start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        chk("abort_in_eval", {bus.busy, bus.rsshr, bus.rsload}, 3'b110);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs", outs(), '0);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'd3, 4'd5, 4'b0000, 1'b0, 1'b0, 2);
        check_op("after_rst", 64'h12332334, 8, 16'h0000, 2, 15);
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy | bus.done) busy_seen++;
        end
        chk("busy_start_ignored", busy_seen, 0);

        run_op(4'd7, 4'd9, 4'b1000, 1'b0, 1'b1, 0);
        check_op("b2b_7x9", 64'h12333234, 8, 16'h01C0, 2, 63);
        a_in = 4'd2; b_in = 4'd2; bt_in = 4'b0000; bus.start_t = 1'b0;
        @(negedge clk);
        chk("b2b_gap", outs(), '0);
        run_op(4'd2, 4'd2, 4'b0000, 1'b0, 1'b1, 0);
        check_op("b2b_2x2", 64'h1323334, 7, 16'h0000, 1, 4);
        bus.start = 1'b0;
        @(negedge clk);
        chk("final_idle", outs(), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
